hub75_frame_buffer: RTL and testbench

- Double-buffered pixel store that sits directly upstream of the HUB75 panel driver.
- A host-side writer fills the back buffer one RGB555 pixel at a time, then commits it.
- The panel driver reads the front buffer by row, column and bit-plane, and receives the six shift-data bits (r0,g0,b0,r1,g1,b1) for the top and bottom panel halves.
- Buffers swap only on the driver's frame-sync pulse, so a frame is never displayed half-written.

---
 rtl/hub75_pkg.sv | 40 ++++
 rtl/hub75_dpram.sv | 31 +++
 rtl/hub75_frame_buffer.sv | 156 +++++++++++++++
 tb/tb_hub75_frame_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 double-buffered frame store.
// Pixel layout is RGB555; panel shift bits are ordered r0,g0,b0,r1,g1,b1.
package hub75_pkg;

   localparam int unsigned DefCols     = 64;
   localparam int unsigned DefRowsHalf = 32;
   localparam int unsigned DefPlanes   = 5;

   localparam int unsigned PixW  = 15;
   localparam int unsigned ChanW = 5;
   localparam int unsigned RLsb  = 10;
   localparam int unsigned GLsb  = 5;
   localparam int unsigned BLsb  = 0;

   localparam int unsigned RgbR0 = 0;
   localparam int unsigned RgbG0 = 1;
   localparam int unsigned RgbB0 = 2;
   localparam int unsigned RgbR1 = 3;
   localparam int unsigned RgbG1 = 4;
   localparam int unsigned RgbB1 = 5;

   typedef enum logic [0:0] {
      StIdle,
      StPending
   } swap_state_e;

   // Returns {b, g, r} bits of one pixel at the given bit-plane.
   // Channels are zero-extended to 8 bits so any 3-bit plane index stays in range.
   function automatic logic [2:0] plane_bits(input logic [PixW-1:0] pix,
                                             input logic [2:0]      plane);
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      r = {3'b000, pix[RLsb +: ChanW]};
      g = {3'b000, pix[GLsb +: ChanW]};
      b = {3'b000, pix[BLsb +: ChanW]};
      return {b[plane], g[plane], r[plane]};
   endfunction

endpackage

// File: rtl/hub75_dpram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// Read-during-write to the same address returns the previous contents.
module hub75_dpram #(
   parameter  int unsigned Width = 15,
   parameter  int unsigned Depth = 2048,
   localparam int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/hub75_frame_buffer.sv
// Double-buffered RGB555 pixel store feeding a HUB75 panel driver.
// Host writes the back bank; banks swap only on the driver's frame-sync after a commit.
module hub75_frame_buffer
   import hub75_pkg::*;
#(
   parameter  int unsigned COLS      = DefCols,
   parameter  int unsigned ROWS_HALF = DefRowsHalf,
   parameter  int unsigned PLANES    = DefPlanes,
   localparam int unsigned ColW      = $clog2(COLS),
   localparam int unsigned RowW      = $clog2(ROWS_HALF)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_wr_valid,
   output logic            o_wr_ready,
   input  logic [ColW-1:0] i_wr_x,
   input  logic [RowW:0]   i_wr_y,
   input  logic [14:0]     i_wr_data,
   input  logic            i_wr_commit,
   input  logic            i_frame_sync,
   input  logic            i_rd_req,
   input  logic [RowW-1:0] i_rd_row,
   input  logic [ColW-1:0] i_rd_col,
   input  logic [2:0]      i_rd_plane,
   output logic            o_rd_valid,
   output logic [5:0]      o_rgb,
   output logic            o_front_sel,
   output logic            o_swap_pending
);

   localparam int unsigned Depth    = ROWS_HALF * COLS;
   localparam int unsigned AddrW    = RowW + ColW;
   localparam logic [3:0]  PlaneLim = 4'(PLANES);

   // Swap FSM
   swap_state_e state_q, state_d;
   logic        front_sel_q, front_sel_d;
   logic        wr_ready_q;

   always_comb begin
      state_d     = state_q;
      front_sel_d = front_sel_q;
      unique case (state_q)
         StIdle: begin
            // A sync arriving with the commit is too early; wait for the next one.
            if (i_wr_commit) begin
               state_d = StPending;
            end
         end
         StPending: begin
            if (i_frame_sync) begin
               state_d     = StIdle;
               front_sel_d = ~front_sel_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= StIdle;
         front_sel_q <= 1'b0;
         wr_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         front_sel_q <= front_sel_d;
         wr_ready_q  <= (state_d == StIdle);
      end
   end

   assign o_wr_ready     = wr_ready_q;
   assign o_front_sel    = front_sel_q;
   assign o_swap_pending = (state_q == StPending);

   // Storage: index = {bank, bottom_half}
   logic             wr_fire;
   logic             wr_bot;
   logic [AddrW-1:0] wr_addr;
   logic [AddrW-1:0] rd_addr;
   logic [3:0]       ram_we;
   logic [14:0]      ram_rdata [4];

   assign wr_fire = i_wr_valid & wr_ready_q;
   assign wr_bot  = i_wr_y[RowW];
   assign wr_addr = {i_wr_y[RowW-1:0], i_wr_x};
   assign rd_addr = {i_rd_row, i_rd_col};

   for (genvar i = 0; i < 4; i++) begin : g_ram
      localparam logic RamBank = 1'(i / 2);
      localparam logic RamBot  = 1'(i % 2);

      assign ram_we[i] = wr_fire & (RamBank == ~front_sel_q) & (RamBot == wr_bot);

      hub75_dpram #(
         .Width (15),
         .Depth (Depth)
      ) u_ram (
         .clk_i   (i_clk),
         .we_i    (ram_we[i]),
         .waddr_i (wr_addr),
         .wdata_i (i_wr_data),
         .re_i    (i_rd_req),
         .raddr_i (rd_addr),
         .rdata_o (ram_rdata[i])
      );
   end

   // Read pipeline: stage 1 aligns with RAM output, stage 2 holds the plane-muxed bits
   logic        rd_valid1_q;
   logic        rd_bank1_q;
   logic [2:0]  rd_plane1_q;
   logic        rd_valid_q;
   logic [5:0]  rgb_q;
   logic [5:0]  rgb_d;
   logic [14:0] pix_top;
   logic [14:0] pix_bot;
   logic [2:0]  top_bits;
   logic [2:0]  bot_bits;

   always_comb begin
      pix_top  = rd_bank1_q ? ram_rdata[2] : ram_rdata[0];
      pix_bot  = rd_bank1_q ? ram_rdata[3] : ram_rdata[1];
      top_bits = plane_bits(pix_top, rd_plane1_q);
      bot_bits = plane_bits(pix_bot, rd_plane1_q);
      rgb_d    = '0;
      if (rd_valid1_q && ({1'b0, rd_plane1_q} < PlaneLim)) begin
         rgb_d[RgbR0] = top_bits[0];
         rgb_d[RgbG0] = top_bits[1];
         rgb_d[RgbB0] = top_bits[2];
         rgb_d[RgbR1] = bot_bits[0];
         rgb_d[RgbG1] = bot_bits[1];
         rgb_d[RgbB1] = bot_bits[2];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_valid1_q <= 1'b0;
         rd_bank1_q  <= 1'b0;
         rd_plane1_q <= '0;
         rd_valid_q  <= 1'b0;
         rgb_q       <= '0;
      end else begin
         rd_valid1_q <= i_rd_req;
         rd_bank1_q  <= front_sel_q;
         rd_plane1_q <= i_rd_plane;
         rd_valid_q  <= rd_valid1_q;
         rgb_q       <= rgb_d;
      end
   end

   assign o_rd_valid = rd_valid_q;
   assign o_rgb      = rgb_q;

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Self-checking bench for hub75_frame_buffer: a bank/FSM reference model pushes expected
// read results into a queue at request time; a negedge monitor pops and compares outputs.
module tb_hub75_frame_buffer;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_wr_valid = 1'b0;
   logic       o_wr_ready;
   logic [5:0] i_wr_x = '0;
   logic [5:0] i_wr_y = '0;
   logic [14:0] i_wr_data = '0;
   logic       i_wr_commit = 1'b0;
   logic       i_frame_sync = 1'b0;
   logic       i_rd_req = 1'b0;
   logic [4:0] i_rd_row = '0;
   logic [5:0] i_rd_col = '0;
   logic [2:0] i_rd_plane = '0;
   logic       o_rd_valid;
   logic [5:0] o_rgb;
   logic       o_front_sel;
   logic       o_swap_pending;

   always #5 i_clk = ~i_clk;

   hub75_frame_buffer u_dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_wr_valid     (i_wr_valid),
      .o_wr_ready     (o_wr_ready),
      .i_wr_x         (i_wr_x),
      .i_wr_y         (i_wr_y),
      .i_wr_data      (i_wr_data),
      .i_wr_commit    (i_wr_commit),
      .i_frame_sync   (i_frame_sync),
      .i_rd_req       (i_rd_req),
      .i_rd_row       (i_rd_row),
      .i_rd_col       (i_rd_col),
      .i_rd_plane     (i_rd_plane),
      .o_rd_valid     (o_rd_valid),
      .o_rgb          (o_rgb),
      .o_front_sel    (o_front_sel),
      .o_swap_pending (o_swap_pending)
   );

   int          checks = 0;
   int          errors = 0;
   logic [5:0]  exp_q [$];
   logic [14:0] mem_m [2][4096];
   int          front_m = 0;
   bit          pend_m = 1'b0;

   function automatic logic [5:0] exp_rgb(int bank, int row, int col, int plane);
      logic [14:0] t;
      logic [14:0] b;
      if (plane >= 5) return 6'b000000;
      t = mem_m[bank][row * 64 + col];
      b = mem_m[bank][(row + 32) * 64 + col];
      return {b[plane], b[5 + plane], b[10 + plane], t[plane], t[5 + plane], t[10 + plane]};
   endfunction

   // One clock: update the model with what the DUT samples, then release pulses.
   task automatic step();
      @(posedge i_clk);
      if (!i_rst) begin
         if (i_rd_req) begin
            exp_q.push_back(exp_rgb(front_m, int'(i_rd_row), int'(i_rd_col), int'(i_rd_plane)));
         end
         if (i_wr_valid && !pend_m) begin
            mem_m[1 - front_m][int'(i_wr_y) * 64 + int'(i_wr_x)] = i_wr_data;
         end
         if (!pend_m && i_wr_commit) begin
            pend_m = 1'b1;
         end else if (pend_m && i_frame_sync) begin
            pend_m  = 1'b0;
            front_m = 1 - front_m;
         end
      end
      #1;
      i_wr_valid   = 1'b0;
      i_wr_commit  = 1'b0;
      i_frame_sync = 1'b0;
      i_rd_req     = 1'b0;
   endtask

   task automatic set_wr(int x, int y, logic [14:0] d);
      i_wr_valid = 1'b1;
      i_wr_x     = 6'(x);
      i_wr_y     = 6'(y);
      i_wr_data  = d;
   endtask

   task automatic set_rd(int row, int col, int plane);
      i_rd_req   = 1'b1;
      i_rd_row   = 5'(row);
      i_rd_col   = 6'(col);
      i_rd_plane = 3'(plane);
   endtask

   task automatic drain(string name);
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d reads outstanding, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   always @(negedge i_clk) begin
      if (!i_rst && o_rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: o_rd_valid=1 with no read outstanding, rgb=%b", o_rgb);
         end else begin
            logic [5:0] e;
            e = exp_q.pop_front();
            if (o_rgb !== e) begin
               errors++;
               $display("FAIL rd_data: got %b want %b", o_rgb, e);
            end
         end
      end
   end

   task automatic test_reset();
      #1 i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      checks += 5;
      if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %b want 0", o_wr_ready); end
      if (o_front_sel !== 1'b0) begin errors++; $display("FAIL rst_front: got %b want 0", o_front_sel); end
      if (o_swap_pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b want 0", o_swap_pending); end
      if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b want 0", o_rd_valid); end
      if (o_rgb !== 6'b0) begin errors++; $display("FAIL rst_rgb: got %b want 0", o_rgb); end
      i_rst = 1'b0;
      step();
      checks++;
      if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", o_wr_ready); end
   endtask

   task automatic test_init();
      int rows [3] = '{1, 2, 5};
      int cols [2] = '{3, 10};
      for (int pass = 0; pass < 2; pass++) begin
         for (int r = 0; r < 3; r++)
            for (int h = 0; h < 2; h++)
               for (int c = 0; c < 2; c++) begin
                  set_wr(cols[c], rows[r] + 32 * h, 15'($urandom));
                  step();
               end
         i_wr_commit = 1'b1;
         step();
         i_frame_sync = 1'b1;
         step();
         checks++;
         if (o_front_sel !== 1'(front_m)) begin
            errors++; $display("FAIL init_front: got %b want %0d", o_front_sel, front_m);
         end
      end
   endtask

   task automatic test_isolation();
      logic [14:0] d;
      d = ~mem_m[front_m][1 * 64 + 3];
      set_wr(3, 1, d);
      step();
      for (int p = 0; p < 5; p++) begin set_rd(1, 3, p); step(); end
      drain("iso_before");
      i_wr_commit = 1'b1;
      step();
      i_frame_sync = 1'b1;
      step();
      checks++;
      if (o_front_sel !== 1'b1) begin errors++; $display("FAIL iso_front: got %b want 1", o_front_sel); end
      for (int p = 0; p < 5; p++) begin set_rd(1, 3, p); step(); end
      drain("iso_after");
   endtask

   task automatic test_bottom_half();
      set_wr(10, 5, 15'h0000);
      step();
      set_wr(10, 37, 15'b00000_00100_00000);
      step();
      i_wr_commit = 1'b1;
      step();
      i_frame_sync = 1'b1;
      step();
      set_rd(5, 10, 2);
      step();
      set_rd(5, 10, 1);
      step();
      checks++;
      if (o_rgb !== 6'b010000) begin errors++; $display("FAIL bot_plane2: got %b want 010000", o_rgb); end
      step();
      checks++;
      if (o_rgb !== 6'b000000) begin errors++; $display("FAIL bot_plane1: got %b want 000000", o_rgb); end
      drain("bot");
   endtask

   task automatic test_handshake();
      logic [14:0] da;
      logic [14:0] db;
      da = ~mem_m[front_m][2 * 64 + 10];
      db = ~mem_m[1 - front_m][2 * 64 + 3];
      set_wr(10, 2, da);
      i_wr_commit = 1'b1;
      step();
      checks += 2;
      if (o_swap_pending !== 1'b1) begin errors++; $display("FAIL hs_pending: got %b want 1", o_swap_pending); end
      if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_low: got %b want 0", o_wr_ready); end
      for (int i = 0; i < 3; i++) begin
         set_wr(3, 2, db);
         step();
         checks++;
         if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL hs_blocked_%0d: ready %b want 0", i, o_wr_ready); end
      end
      i_frame_sync = 1'b1;
      step();
      checks += 2;
      if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_high: got %b want 1", o_wr_ready); end
      if (o_front_sel !== 1'(front_m)) begin errors++; $display("FAIL hs_front: got %b want %0d", o_front_sel, front_m); end
      for (int p = 0; p < 5; p++) begin set_rd(2, 10, p); step(); set_rd(2, 3, p); step(); end
      drain("hs");
   endtask

   task automatic test_same_cycle();
      logic f0;
      f0 = o_front_sel;
      i_wr_commit  = 1'b1;
      i_frame_sync = 1'b1;
      step();
      checks += 2;
      if (o_swap_pending !== 1'b1) begin errors++; $display("FAIL same_pending: got %b want 1", o_swap_pending); end
      if (o_front_sel !== f0) begin errors++; $display("FAIL same_noswap: got %b want %b", o_front_sel, f0); end
      i_frame_sync = 1'b1;
      step();
      checks += 2;
      if (o_front_sel !== ~f0) begin errors++; $display("FAIL same_swap: got %b want %b", o_front_sel, ~f0); end
      if (o_swap_pending !== 1'b0) begin errors++; $display("FAIL same_cleared: got %b want 0", o_swap_pending); end
   endtask

   task automatic test_back_to_back();
      set_wr(10, 5, ~mem_m[front_m][5 * 64 + 10]);
      step();
      set_wr(10, 37, ~mem_m[front_m][37 * 64 + 10]);
      step();
      i_wr_commit = 1'b1;
      step();
      for (int k = 1; k <= 6; k++) begin
         set_rd(5, 10, k % 5);
         if (k == 3) i_frame_sync = 1'b1;
         step();
         if (k >= 2) begin
            checks++;
            if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d: got %b want 1", k, o_rd_valid); end
         end
      end
      step();
      checks++;
      if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_last: got %b want 1", o_rd_valid); end
      drain("b2b");
   endtask

   task automatic test_reset_midop();
      i_wr_commit = 1'b1;
      step();
      set_rd(5, 10, 0);
      step();
      set_rd(5, 10, 1);
      step();
      i_rst = 1'b1;
      exp_q.delete();
      pend_m  = 1'b0;
      front_m = 0;
      #1;
      checks += 3;
      if (o_swap_pending !== 1'b0) begin errors++; $display("FAIL mid_pending: got %b want 0", o_swap_pending); end
      if (o_front_sel !== 1'b0) begin errors++; $display("FAIL mid_front: got %b want 0", o_front_sel); end
      if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid: got %b want 0", o_rd_valid); end
      step();
      step();
      i_rst = 1'b0;
      step();
      checks++;
      if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", o_wr_ready); end
      set_rd(5, 10, 7);
      step();
      step();
      checks += 2;
      if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL plane7_valid: got %b want 1", o_rd_valid); end
      if (o_rgb !== 6'b000000) begin errors++; $display("FAIL plane7_rgb: got %b want 000000", o_rgb); end
      drain("plane7");
   endtask

   initial begin
      test_reset();
      test_init();
      test_isolation();
      test_bottom_half();
      test_handshake();
      test_same_cycle();
      test_back_to_back();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
